// File: rtl/timer_device.sv
// timer_device: memory-mapped countdown timer with one-shot and auto-reload
// modes. It answers bridge register accesses combinationally, decrements a
// counter every clock while enabled, and raises a level interrupt on expiry.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stopped; waits for CTRL.EN
// LOAD  | copies PRESET into COUNT
// CNT   | counts down; expiry sets pending, clearing EN stops the count
// INT   | one cycle after expiry; reloads (auto) or clears EN (one-shot)
module timer_device (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] IDX_CTRL   = 2'd0;
    localparam logic [1:0] IDX_PRESET = 2'd1;
    localparam logic [1:0] IDX_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO  = 2'b01;

    state_t      state;
    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pending;

    logic [1:0]  idx;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        auto_reload;
    logic        expire;
    logic        unused_addr_bits;

    // Only the word index is decoded; the remaining address bits are don't-care.
    assign idx              = addr[3:2];
    assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

    assign wr_ctrl     = en && we && (idx == IDX_CTRL);
    assign wr_preset   = en && we && (idx == IDX_PRESET);

    // MODE 10 and 11 fall back to one-shot behaviour.
    assign auto_reload = (ctrl_mode == MODE_AUTO);

    // Final decrement step: COUNT of 0 or 1 while still enabled in CNT.
    assign expire      = (state == ST_CNT) && ctrl_en && (count <= 32'd1);

    assign irq = pending && ctrl_im;

    // CPU-only configuration fields: MODE, IM and PRESET.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
            preset    <= 32'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl_mode <= wdata[2:1];
                ctrl_im   <= wdata[3];
            end
            if (wr_preset) begin
                preset <= wdata;
            end
        end
    end

    // Sequencer: state, COUNT, pending and the EN bit shared with the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            count   <= 32'd0;
            pending <= 1'b0;
            ctrl_en <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_en) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count <= 32'd0;
                        state <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (auto_reload) begin
                        state <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // A set on the same edge as any clear wins so no expiry is lost.
            if (expire) begin
                pending <= 1'b1;
            end else if (wr_ctrl || wr_preset) begin
                pending <= 1'b0;
            end else if ((state == ST_INT) && auto_reload) begin
                pending <= 1'b0;
            end

            // A CPU write of CTRL overrides the one-shot self-disable.
            if (wr_ctrl) begin
                ctrl_en <= wdata[0];
            end else if ((state == ST_INT) && !auto_reload) begin
                ctrl_en <= 1'b0;
            end
        end
    end

    // Side-effect-free register read mux, independent of the select strobe.
    always_comb begin
        rdata = 32'd0;
        case (idx)
            IDX_CTRL:   rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            IDX_PRESET: rdata = preset;
            IDX_COUNT:  rdata = count;
            default:    rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: directed scoreboard bench for timer_device.
module tb_timer_device;

    logic        clk;
    logic        reset;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    timer_device dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        en    = 1'b1;
        we    = 1'b1;
        @(posedge clk);
        #1;
        en    = 1'b0;
        we    = 1'b0;
    endtask

    task automatic read_chk(input logic [31:0] a, input logic [31:0] e, input string tag);
        exp_t        x;
        logic [31:0] got;
        sb.push_back('{tag: tag, exp: e});
        addr = a;
        #1;
        got = rdata;
        x = sb.pop_front();
        vectors++;
        assert (got === x.exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", x.tag, got, x.exp);
        end
    endtask

    task automatic irq_chk(input logic e, input string tag);
        exp_t        x;
        logic [31:0] got;
        sb.push_back('{tag: tag, exp: {31'd0, e}});
        got = {31'd0, irq};
        x = sb.pop_front();
        vectors++;
        assert (got === x.exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", x.tag, got, x.exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        read_chk(32'h0, 32'h0, "rst_ctrl");
        read_chk(32'h4, 32'h0, "rst_preset");
        read_chk(32'h8, 32'h0, "rst_count");
        read_chk(32'hC, 32'h0, "rst_resv");
        irq_chk(1'b0, "rst_irq");
        reset = 1'b0;
        tick();

        // Reset asserted mid-count
        wr(32'h4, 32'd7);
        wr(32'h0, 32'h9);
        repeat (4) tick();
        read_chk(32'h8, 32'd5, "midrst_pre_count");
        reset = 1'b1;
        #1;
        read_chk(32'h0, 32'h0, "midrst_ctrl");
        read_chk(32'h4, 32'h0, "midrst_preset");
        read_chk(32'h8, 32'h0, "midrst_count");
        irq_chk(1'b0, "midrst_irq");
        tick();
        reset = 1'b0;
        repeat (4) tick();
        read_chk(32'h8, 32'h0, "post_rst_count");
        irq_chk(1'b0, "post_rst_irq");

        // One-shot, IM=1
        wr(32'h4, 32'd5);
        wr(32'h0, 32'h9);
        tick();
        read_chk(32'h8, 32'd0, "os_load_count");
        irq_chk(1'b0, "os_load_irq");
        for (int k = 2; k <= 7; k++) begin
            tick();
            read_chk(32'h8, 32'(7 - k), "os_count");
            irq_chk(k == 7, "os_irq");
        end
        tick();
        read_chk(32'h0, 32'h8, "os_ctrl_en_cleared");
        irq_chk(1'b1, "os_irq_held");
        tick();
        irq_chk(1'b1, "os_irq_held2");
        wr(32'h0, 32'h8);
        irq_chk(1'b0, "os_irq_cleared");

        // Masked one-shot
        wr(32'h4, 32'd5);
        wr(32'h0, 32'h1);
        repeat (7) tick();
        read_chk(32'h8, 32'd0, "mask_count");
        irq_chk(1'b0, "mask_irq");
        tick();
        read_chk(32'h0, 32'h0, "mask_ctrl");
        wr(32'h0, 32'h8);
        irq_chk(1'b0, "mask_unmask_irq");
        tick();
        irq_chk(1'b0, "mask_unmask_irq2");

        // Auto-reload, period N+2
        wr(32'h4, 32'd3);
        wr(32'h0, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            logic [31:0] ce;
            tick();
            if (k == 1) begin
                ce = 32'd0;
            end else begin
                case ((k - 2) % 5)
                    0:       ce = 32'd3;
                    1:       ce = 32'd2;
                    2:       ce = 32'd1;
                    default: ce = 32'd0;
                endcase
            end
            read_chk(32'h8, ce, "auto_count");
            irq_chk((k >= 5) && (((k - 5) % 5) == 0), "auto_irq");
        end
        wr(32'h0, 32'h0);
        read_chk(32'h8, 32'd2, "auto_stop_count");
        tick();
        read_chk(32'h8, 32'd2, "auto_stop_frozen");
        irq_chk(1'b0, "auto_stop_irq");

        // Disable mid-count, then re-enable
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h1);
        repeat (6) tick();
        read_chk(32'h8, 32'd6, "dis_count6");
        wr(32'h0, 32'h8);
        read_chk(32'h8, 32'd5, "dis_count5");
        repeat (3) tick();
        read_chk(32'h8, 32'd5, "dis_frozen");
        irq_chk(1'b0, "dis_irq");
        wr(32'h0, 32'h9);
        read_chk(32'h8, 32'd5, "reen_e0");
        tick();
        read_chk(32'h8, 32'd5, "reen_load");
        tick();
        read_chk(32'h8, 32'd10, "reen_reloaded");
        wr(32'h0, 32'h0);
        tick();
        read_chk(32'h8, 32'd9, "reen_stopped");

        // Ignored writes and address aliasing
        wr(32'h8, 32'h1234);
        read_chk(32'h8, 32'd9, "ign_count_write");
        wr(32'hC, 32'hFFFF_FFFF);
        read_chk(32'hC, 32'h0, "ign_resv_read");
        read_chk(32'h0, 32'h0, "ign_resv_ctrl");
        read_chk(32'h4, 32'd10, "ign_resv_preset");
        wr(32'h0, 32'hFFFF_FFF0);
        read_chk(32'h0, 32'h0, "ctrl_upper_bits");
        read_chk(32'h104, 32'd10, "addr_alias_preset");

        // PRESET write on the expiry edge: set wins
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h9);
        repeat (3) tick();
        read_chk(32'h8, 32'd1, "same_edge_pre");
        wr(32'h4, 32'd7);
        irq_chk(1'b1, "same_edge_irq");
        read_chk(32'h8, 32'd0, "same_edge_count");
        tick();
        read_chk(32'h0, 32'h8, "same_edge_ctrl");
        read_chk(32'h4, 32'd7, "same_edge_preset");
        irq_chk(1'b1, "same_edge_irq_held");
        wr(32'h0, 32'h8);
        irq_chk(1'b0, "same_edge_cleared");

        // CTRL write on the self-disable edge: CPU value wins
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h9);
        repeat (4) tick();
        irq_chk(1'b1, "cpu_wins_int_irq");
        wr(32'h0, 32'h9);
        read_chk(32'h0, 32'h9, "cpu_wins_ctrl");
        irq_chk(1'b0, "cpu_wins_irq");
        repeat (2) tick();
        read_chk(32'h8, 32'd2, "cpu_wins_reload");
        wr(32'h0, 32'h0);
        tick();

        // MODE 10 acts as one-shot, PRESET 0 acts as 1
        wr(32'h4, 32'd0);
        wr(32'h0, 32'hD);
        repeat (2) tick();
        read_chk(32'h8, 32'd0, "p0_count");
        irq_chk(1'b0, "p0_irq_early");
        tick();
        irq_chk(1'b1, "p0_irq");
        tick();
        read_chk(32'h0, 32'hC, "mode10_ctrl");
        irq_chk(1'b1, "mode10_irq_held");
        wr(32'h0, 32'h8);
        irq_chk(1'b0, "mode10_cleared");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/timer_device.md
# timer_device

Memory-mapped programmable countdown timer that sits behind the data bridge as the responder for CPU word loads/stores. It answers the bridge's register reads and writes combinationally. It decrements a counter every clock and raises an interrupt line that the top level routes into one bit of the CPU's `hw_int` vector.

## Interface

Parameters
- none

Ports
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- en  input  1  device selected by bridge this cycle (address decoded into this device's window)
- we  input  1  store strobe; register write happens only when en & we
- addr  input  32  byte address from bridge; only addr[3:2] decoded, other bits ignored
- wdata  input  32  store data (word access only; the bridge rejects sub-word access to this device)
- rdata  output  32  combinational read data for addr[3:2], independent of en
- irq  output  1  interrupt request, level, = pending & CTRL.IM

## Operation

Registers (word index = addr[3:2])
- 0 CTRL: bit0 EN, bits[2:1] MODE, bit3 IM; bits[31:4] read 0, writes ignored
- 1 PRESET: 32-bit reload value, R/W
- 2 COUNT: 32-bit current count, read-only; writes ignored
- 3 reserved: reads 0, writes ignored
- MODE 00 = one-shot; 01 = auto-reload; 10/11 behave as 00

FSM states: IDLE, LOAD, CNT, INT
- IDLE: EN=1 -> LOAD; else stay
- LOAD: COUNT <= PRESET -> CNT
- CNT: EN=0 -> IDLE, COUNT frozen. Else if COUNT > 1: COUNT <= COUNT-1. Else (COUNT is 0 or 1): COUNT <= 0, pending <= 1 -> INT
- INT, one-shot: CTRL.EN <= 0 -> IDLE; pending held
- INT, auto-reload: -> LOAD; pending cleared on this transition, so pending is high only during the INT cycle

Pending / irq rules
- One-shot pending clears on any CPU write to CTRL or PRESET.
- If a clear event and the FSM set of pending land on the same edge, the set wins, so no interrupt is lost.
- A CPU write to CTRL on the same edge as the FSM clears EN in INT: the CPU value wins.
- PRESET writes do not affect a count in progress; they take effect at the next LOAD.
- Reads have no side effects.

## Timing

- Reset values: CTRL=0, PRESET=0, COUNT=0, pending=0, state IDLE, irq=0. rdata follows the registers (0 for every addr after reset).
- Reset asserted mid-count: immediate return to reset values; no irq glitch after release.
- Write latency: a register is updated on the edge where en & we is high. rdata shows the new value from the following cycle.
- Start latency: EN written at edge E0 gives LOAD at E1, COUNT=PRESET at E2, and INT plus pending set at E(2+N) for PRESET=N≥1. PRESET=0 behaves as PRESET=1.
- irq is high in the cycle after the edge that sets pending, provided IM=1.
- Auto-reload period: N+2 cycles between INT entries; irq pulse width is 1 cycle.
- COUNT never wraps: it saturates at 0 and is never decremented from 0.
- Writing EN=0 during CNT: the FSM reaches IDLE on the next edge, and COUNT holds its value at that point.

## Test plan

- **Reset:** assert reset mid-count with PRESET=7, EN=1 -> all reads 0 and irq=0 immediately; state IDLE after release.
- **One-shot:** write PRESET=5, then CTRL=0x9 (EN, IM, MODE 00) at edge E0 -> COUNT reads 5,4,3,2,1,0. irq rises after E7 and stays high. CTRL reads 0x8 (EN cleared). A CTRL write of 0x8 drops irq the next cycle.
- **Mask:** same as the one-shot case with CTRL=0x1 (IM=0) -> irq stays 0. A later write of IM=1 via CTRL=0x8 clears pending, so irq stays 0.
- **Auto-reload:** PRESET=3, CTRL=0xB -> irq is a 1-cycle pulse every 5 cycles for at least 4 periods. COUNT sequence is 3,2,1,0,(LOAD)...
- **Disable mid-count:** PRESET=10, EN=1. Write CTRL=0x8 while COUNT=6 -> COUNT freezes at 5 or 6 per the one-edge latency rule, and irq never rises. Re-enabling reloads from PRESET.
- **Ignored writes and same-edge set:** a write to COUNT and to index 3 -> no register changes. A PRESET write on the same edge the FSM enters INT (one-shot) -> pending=1 and irq=1.
